// File: rtl/cd_sector_sequencer.sv
// cd_sector_sequencer
//   Frames the raw 16-bit CD word stream into 2352-byte sectors. It hunts for the
//   12-byte sync pattern, locks onto it, and captures the 4-byte header. Header and
//   data words go into a small show-ahead FIFO. The FIFO paces SH-1 DMA channel 0
//   through a DREQ/RD handshake.
// Ports
//   CLK, RST_N      clock, asynchronous active-low reset
//   EN              transfer enable; low flushes the FIFO and blocks pushes
//   WORD_VLD/WORD_D stream word strobe/data ([7:0] is the earlier byte on disc)
//   RD              pop strobe from the DMA side
//   DOUT            FIFO head word (0 when empty)
//   DREQ            DMA request (registered)
//   LEVEL           FIFO occupancy
//   SYNCED          high while framing data words
//   HDR/HDR_VLD     last captured header {word6, word7} / one-cycle update pulse
//   SECTOR_END      one-cycle pulse after the last word of a sector
//   OVERRUN/CLR_OVR sticky drop flag / its clear strobe
module cd_sector_sequencer #(
    parameter int SECTOR_WORDS = 1176,
    parameter int FIFO_DEPTH   = 16,
    parameter int DREQ_THRESH  = 8,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          EN,
    input  logic          WORD_VLD,
    input  logic [15:0]   WORD_D,
    input  logic          RD,
    output logic [15:0]   DOUT,
    output logic          DREQ,
    output logic [LW-1:0] LEVEL,
    output logic          SYNCED,
    output logic [31:0]   HDR,
    output logic          HDR_VLD,
    output logic          SECTOR_END,
    output logic          OVERRUN,
    input  logic          CLR_OVR
);
    typedef enum logic {HUNT, DATA} state_t;

    state_t        state, state_n;
    logic [10:0]   cnt, cnt_n;
    logic          data_word, hdr_hi_ld, hdr_lo_ld, last_word;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          tail;
    logic          empty, full, push_req, do_push, do_pop, drop;

    // Sync pattern: FF00, FFFF x4, 00FF
    function automatic logic [15:0] sync_word(input logic [10:0] idx);
        case (idx)
            11'd0:   sync_word = 16'hFF00;
            11'd5:   sync_word = 16'h00FF;
            default: sync_word = 16'hFFFF;
        endcase
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= HUNT;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        data_word = 1'b0;
        hdr_hi_ld = 1'b0;
        hdr_lo_ld = 1'b0;
        last_word = 1'b0;
        if (WORD_VLD) begin
            case (state)
                HUNT: begin
                    if (WORD_D == sync_word(cnt)) begin
                        if (cnt == 11'd5) begin
                            state_n = DATA;
                            cnt_n   = 11'd6;
                        end else begin
                            cnt_n = cnt + 11'd1;
                        end
                    end else begin
                        // A stray FF00 may itself be the start of a real sync.
                        cnt_n = (WORD_D == 16'hFF00) ? 11'd1 : 11'd0;
                    end
                end
                DATA: begin
                    data_word = 1'b1;
                    hdr_hi_ld = (cnt == 11'd6);
                    hdr_lo_ld = (cnt == 11'd7);
                    if (cnt == 11'(SECTOR_WORDS - 1)) begin
                        last_word = 1'b1;
                        state_n   = HUNT;
                        cnt_n     = '0;
                    end else begin
                        cnt_n = cnt + 11'd1;
                    end
                end
                default: begin
                    state_n = HUNT;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign SYNCED   = (state == DATA);
    assign empty    = (LEVEL == '0);
    assign full     = (LEVEL == LW'(FIFO_DEPTH));
    assign push_req = data_word & EN;
    assign do_pop   = RD & EN & ~empty;
    // A simultaneous pop frees the head slot, so a full FIFO can still accept.
    assign do_push  = push_req & (~full | do_pop);
    assign drop     = push_req & full & ~do_pop;
    assign DOUT     = empty ? 16'h0000 : mem[rptr];

    always_ff @(posedge CLK) begin
        if (do_push) mem[wptr] <= WORD_D;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr  <= '0;
            rptr  <= '0;
            LEVEL <= '0;
        end else if (!EN) begin
            wptr  <= '0;
            rptr  <= '0;
            LEVEL <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   LEVEL <= LEVEL + LW'(1);
                2'b01:   LEVEL <= LEVEL - LW'(1);
                default: LEVEL <= LEVEL;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            HDR        <= '0;
            HDR_VLD    <= 1'b0;
            SECTOR_END <= 1'b0;
            OVERRUN    <= 1'b0;
            tail       <= 1'b0;
            DREQ       <= 1'b0;
        end else begin
            if (hdr_hi_ld) HDR[31:16] <= WORD_D;
            if (hdr_lo_ld) HDR[15:0]  <= WORD_D;
            HDR_VLD    <= hdr_lo_ld;
            SECTOR_END <= last_word;
            if (drop)         OVERRUN <= 1'b1;
            else if (CLR_OVR) OVERRUN <= 1'b0;
            // The tail flag lets a short remainder below threshold still drain.
            if (last_word)  tail <= 1'b1;
            else if (empty) tail <= 1'b0;
            DREQ <= EN & ((LEVEL >= LW'(DREQ_THRESH)) | (~empty & tail));
        end
    end
endmodule

// File: tb/tb_cd_sector_sequencer.sv
// Scoreboard bench for cd_sector_sequencer: expected FIFO words are queued as the
// stream is driven and compared against DOUT on every pop.
module tb_cd_sector_sequencer;
    logic        CLK = 1'b0, RST_N = 1'b1, EN = 1'b0, WORD_VLD = 1'b0, RD = 1'b0, CLR_OVR = 1'b0;
    logic [15:0] WORD_D = '0;
    logic [15:0] DOUT;
    logic        DREQ, SYNCED, HDR_VLD, SECTOR_END, OVERRUN;
    logic [4:0]  LEVEL;
    logic [31:0] HDR;

    cd_sector_sequencer dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .WORD_VLD(WORD_VLD), .WORD_D(WORD_D),
        .RD(RD), .DOUT(DOUT), .DREQ(DREQ), .LEVEL(LEVEL), .SYNCED(SYNCED),
        .HDR(HDR), .HDR_VLD(HDR_VLD), .SECTOR_END(SECTOR_END), .OVERRUN(OVERRUN),
        .CLR_OVR(CLR_OVR)
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0, n_err = 0, n_pop = 0, hdr_cnt = 0, sec_cnt = 0;
    logic [15:0] exp_q[$];
    bit          rd_auto = 1'b0, rd_force = 1'b0;
    logic [15:0] sync_w [6] = '{16'hFF00, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h00FF};
    logic [15:0] t2_w   [7] = '{16'hFF00, 16'hFF00, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h00FF};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One word per call, starting and ending on a falling edge.
    task automatic send(input logic [15:0] w, input bit keep);
        WORD_VLD = 1'b1;
        WORD_D   = w;
        if (keep) exp_q.push_back(w);
        @(negedge CLK);
        WORD_VLD = 1'b0;
    endtask

    // DMA side: pops whenever requested, checks the head against the scoreboard.
    always @(negedge CLK) begin
        #1;
        if (HDR_VLD) hdr_cnt++;
        if (SECTOR_END) sec_cnt++;
        if (rd_force || (rd_auto && DREQ && LEVEL != 0)) begin
            RD = 1'b1;
            n_pop++;
            if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
            else                   chk("dout", DOUT, exp_q.pop_front());
        end else begin
            RD = 1'b0;
        end
    end

    initial begin
        int pop0, h0, s0;
        #3 RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_dout", DOUT, 0);      chk("rst_level", LEVEL, 0);
        chk("rst_dreq", DREQ, 0);      chk("rst_synced", SYNCED, 0);
        chk("rst_hdr", HDR, 0);        chk("rst_hdr_vld", HDR_VLD, 0);
        chk("rst_sec_end", SECTOR_END, 0); chk("rst_ovr", OVERRUN, 0);
        RST_N = 1'b1; EN = 1'b1; rd_auto = 1'b1;
        @(negedge CLK);

        // 1: full sector, ramp data, DMA reading on DREQ
        for (int i = 0; i < 6; i++) begin
            send(sync_w[i], 1'b0);
            if (i == 4) chk("t1_synced_early", SYNCED, 0);
            if (i == 5) chk("t1_synced", SYNCED, 1);
            @(negedge CLK);
        end
        pop0 = n_pop; h0 = hdr_cnt; s0 = sec_cnt;
        for (int i = 0; i < 1170; i++) begin
            send(16'(i), 1'b1);
            @(negedge CLK);
        end
        for (int k = 0; k < 300 && LEVEL != 0; k++) @(negedge CLK);
        repeat (3) @(negedge CLK);
        chk("t1_level", LEVEL, 0);     chk("t1_dreq", DREQ, 0);
        chk("t1_pops", n_pop - pop0, 1170);
        chk("t1_hdr", HDR, 32'h0000_0001);
        chk("t1_hdr_vld_cnt", hdr_cnt - h0, 1);
        chk("t1_sec_end_cnt", sec_cnt - s0, 1);
        chk("t1_synced_end", SYNCED, 0);
        chk("t1_sb_left", exp_q.size(), 0);

        // 2: relock via the FF00 restart rule
        rd_auto = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send(t2_w[i], 1'b0);
            if (i == 5) chk("t2_synced_early", SYNCED, 0);
            if (i == 6) chk("t2_synced", SYNCED, 1);
        end

        // 3: fill without reads, overrun and clear
        for (int i = 0; i < 20; i++) begin
            send(16'hA000 + 16'(i), i < 16);
            if (i == 7)  begin chk("t3_level8", LEVEL, 8); chk("t3_dreq_lag", DREQ, 0); end
            if (i == 8)  chk("t3_dreq", DREQ, 1);
            if (i == 15) begin chk("t3_full", LEVEL, 16); chk("t3_no_ovr", OVERRUN, 0); end
            if (i == 16) chk("t3_ovr", OVERRUN, 1);
            if (i == 19) chk("t3_level_hold", LEVEL, 16);
        end
        CLR_OVR = 1'b1;
        @(negedge CLK);
        CLR_OVR = 1'b0;
        chk("t3_ovr_clr", OVERRUN, 0);

        // 4: push and pop together while full
        rd_force = 1'b1;
        send(16'hBEEF, 1'b1);
        rd_force = 1'b0;
        chk("t4_level", LEVEL, 16);
        chk("t4_ovr", OVERRUN, 0);
        chk("t4_dout_adv", DOUT, exp_q[0]);

        // 6: reset mid-sector at LEVEL 5
        rd_force = 1'b1;
        repeat (11) @(negedge CLK);
        rd_force = 1'b0;
        chk("t6_level5", LEVEL, 5);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("t6_dout", DOUT, 0);     chk("t6_level", LEVEL, 0);
        chk("t6_dreq", DREQ, 0);     chk("t6_synced", SYNCED, 0);
        chk("t6_hdr", HDR, 0);       chk("t6_ovr", OVERRUN, 0);
        exp_q.delete();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        rd_auto = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 6; i++) send(sync_w[i], 1'b0);
        chk("t6_relock", SYNCED, 1);

        // 5: short tail below threshold drains after sector end
        s0 = sec_cnt;
        EN = 1'b0;
        for (int i = 0; i < 1170; i++) begin
            if (i == 1167) EN = 1'b1;
            send(16'(i), i >= 1167);
            if (i == 100)  chk("t5_en_low_level", LEVEL, 0);
            if (i == 1168) chk("t5_dreq_below", DREQ, 0);
            if (i == 1169) begin
                chk("t5_sec_end", SECTOR_END, 1);
                chk("t5_level3", LEVEL, 3);
                chk("t5_dreq_pre", DREQ, 0);
            end
        end
        for (int k = 0; k < 6 && !DREQ; k++) @(negedge CLK);
        chk("t5_tail_dreq", DREQ, 1);
        for (int k = 0; k < 50 && LEVEL != 0; k++) @(negedge CLK);
        repeat (3) @(negedge CLK);
        chk("t5_level0", LEVEL, 0);   chk("t5_dreq_drop", DREQ, 0);
        chk("t5_sb_left", exp_q.size(), 0);
        chk("t5_hdr", HDR, 32'h0000_0001);
        chk("t5_sec_end_cnt", sec_cnt - s0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
